// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_wb_arbiter
//  Description : Register-file writeback arbiter. The primary pipeline port has
//                priority; a 2-entry in-order queue holds the secondary writes.
//                Optional macro GPR_WB_TRACE_EN prints each issued write.
//  Revision    : 1.0  initial release
// ============================================================================
module gpr_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_we,
    input  logic [4:0]  p_rw,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_rw,
    input  logic [31:0] s_wd,
    input  logic [31:0] s_pc,
    input  logic [4:0]  q_addr,
    output logic        q_busy,
    output logic        wb_we,
    output logic [4:0]  wb_rw,
    output logic [31:0] wb_wd,
    output logic [31:0] wb_pc
);

    // Queue storage; entry 0 is always the head and valid entries stay packed.
    logic [1:0]  r_valid;
    logic [4:0]  r_rw [2];
    logic [31:0] r_wd [2];
    logic [31:0] r_pc [2];
    logic [1:0]  r_count;

    logic        w_p_issue;
    logic        w_deq;
    logic        w_enq;
    logic        w_issue;
    logic [4:0]  w_iss_rw;
    logic [31:0] w_iss_wd;
    logic [31:0] w_iss_pc;
    logic [1:0]  w_keep;
    logic [1:0]  w_hit;

    logic [1:0]  w_n_valid;
    logic [4:0]  w_n_rw [2];
    logic [31:0] w_n_wd [2];
    logic [31:0] w_n_pc [2];
    logic [1:0]  w_n_count;

    assign s_ready = !reset && (r_count < 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_busy
            assign w_hit[gi] = r_valid[gi] && (r_rw[gi] == q_addr);
        end
    endgenerate

    assign q_busy = !reset && (q_addr != 5'd0) && (|w_hit);

    always_comb begin
        w_p_issue = p_we && (p_rw != 5'd0);
        w_deq     = !w_p_issue && r_valid[0];
        w_enq     = s_valid && s_ready && (s_rw != 5'd0);
        w_issue   = w_p_issue || w_deq;
        w_iss_rw  = w_p_issue ? p_rw : r_rw[0];
        w_iss_wd  = w_p_issue ? p_wd : r_wd[0];
        w_iss_pc  = w_p_issue ? p_pc : r_pc[0];

        // A primary write to the same register supersedes the older queued value.
        for (int i = 0; i < 2; i++) begin
            w_keep[i] = r_valid[i] && !(w_p_issue && (r_rw[i] == p_rw));
        end
        if (w_deq) begin
            w_keep[0] = 1'b0;
        end

        w_n_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_n_rw[i] = r_rw[i];
            w_n_wd[i] = r_wd[i];
            w_n_pc[i] = r_pc[i];
        end

        // Compact survivors to the front, then append the new request behind them.
        if (w_keep[0]) begin
            w_n_valid[0] = 1'b1;
            if (w_keep[1]) begin
                w_n_valid[1] = 1'b1;
            end else if (w_enq) begin
                w_n_valid[1] = 1'b1;
                w_n_rw[1]    = s_rw;
                w_n_wd[1]    = s_wd;
                w_n_pc[1]    = s_pc;
            end
        end else if (w_keep[1]) begin
            w_n_valid[0] = 1'b1;
            w_n_rw[0]    = r_rw[1];
            w_n_wd[0]    = r_wd[1];
            w_n_pc[0]    = r_pc[1];
            if (w_enq) begin
                w_n_valid[1] = 1'b1;
                w_n_rw[1]    = s_rw;
                w_n_wd[1]    = s_wd;
                w_n_pc[1]    = s_pc;
            end
        end else if (w_enq) begin
            w_n_valid[0] = 1'b1;
            w_n_rw[0]    = s_rw;
            w_n_wd[0]    = s_wd;
            w_n_pc[0]    = s_pc;
        end

        w_n_count = {1'b0, w_n_valid[0]} + {1'b0, w_n_valid[1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 2'b00;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_rw[i] <= 5'd0;
                r_wd[i] <= 32'd0;
                r_pc[i] <= 32'd0;
            end
            wb_we <= 1'b0;
            wb_rw <= 5'd0;
            wb_wd <= 32'd0;
            wb_pc <= 32'd0;
        end else begin
            r_valid <= w_n_valid;
            r_count <= w_n_count;
            for (int i = 0; i < 2; i++) begin
                r_rw[i] <= w_n_rw[i];
                r_wd[i] <= w_n_wd[i];
                r_pc[i] <= w_n_pc[i];
            end
            wb_we <= w_issue;
            if (w_issue) begin
                wb_rw <= w_iss_rw;
                wb_wd <= w_iss_wd;
                wb_pc <= w_iss_pc;
            end
`ifdef GPR_WB_TRACE_EN
            if (w_issue) begin
                $display("@%08h: $%2d <= %08h", w_iss_pc, w_iss_rw, w_iss_wd);
            end
`else
`endif
        end
    end

endmodule
`default_nettype wire
